// File: rtl/enc_pkg.sv
// ============================================================================
// Module   : enc_pkg
// Brief    : Kind codes, opcodes, funct3 values and immediate limits for RV32I
// Revision : 1.0
// ============================================================================
`default_nettype none

package enc_pkg;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_ADDI = 4'd1,
    K_LW   = 4'd2,
    K_SW   = 4'd3,
    K_JALR = 4'd4,
    K_BLT  = 4'd5,
    K_BGE  = 4'd6,
    K_JAL  = 4'd7
  } kind_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [6:0] F7_ADD = 7'b0000000;

  localparam int IS_IMM_MIN = -2048;
  localparam int IS_IMM_MAX = 2047;
  localparam int B_IMM_MIN  = -4096;
  localparam int B_IMM_MAX  = 4094;
  localparam int J_IMM_MIN  = -1048576;
  localparam int J_IMM_MAX  = 1048574;

  function automatic logic in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_pack.sv
// ============================================================================
// Module   : instr_pack
// Brief    : Combinational packer: record fields -> {legal, 32-bit machine word}
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_pack
  import enc_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        legal,
  output logic [31:0] word
);

  logic w_is_ok;
  logic w_b_ok;
  logic w_j_ok;

  assign w_is_ok = in_range(imm, IS_IMM_MIN, IS_IMM_MAX);
  assign w_b_ok  = in_range(imm, B_IMM_MIN, B_IMM_MAX) && !imm[0];
  assign w_j_ok  = in_range(imm, J_IMM_MIN, J_IMM_MAX) && !imm[0];

  always_comb begin
    legal = 1'b0;
    word  = 32'd0;
    case (kind)
      K_ADD: begin
        legal = 1'b1;
        word  = {F7_ADD, rs2, rs1, F3_ADD, rd, OP_R};
      end
      K_ADDI: begin
        legal = w_is_ok;
        word  = {imm[11:0], rs1, F3_ADD, rd, OP_I};
      end
      K_LW: begin
        legal = w_is_ok;
        word  = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
      end
      K_SW: begin
        legal = w_is_ok;
        word  = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
      end
      K_JALR: begin
        legal = w_is_ok;
        word  = {imm[11:0], rs1, F3_JALR, rd, OP_JALR};
      end
      K_BLT: begin
        legal = w_b_ok;
        word  = {imm[12], imm[10:5], rs2, rs1, F3_BLT, imm[4:1], imm[11], OP_BRANCH};
      end
      K_BGE: begin
        legal = w_b_ok;
        word  = {imm[12], imm[10:5], rs2, rs1, F3_BGE, imm[4:1], imm[11], OP_BRANCH};
      end
      K_JAL: begin
        legal = w_j_ok;
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      end
      default: begin
        legal = 1'b0;
        word  = 32'd0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Brief    : Two-stage streaming encoder with address tagging and reject count
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_encoder
  import enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_kind,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [31:0] C_ADDR_STEP = 32'(ADDR_STEP);

  logic        r_s1_valid;
  logic [3:0]  r_s1_kind;
  logic [4:0]  r_s1_rd;
  logic [4:0]  r_s1_rs1;
  logic [4:0]  r_s1_rs2;
  logic [31:0] r_s1_imm;
  logic [31:0] r_addr_cnt;

  logic        w_legal;
  logic [31:0] w_word;
  logic        w_s1_move;
  logic        w_in_fire;

  instr_pack u_pack (
    .kind  (r_s1_kind),
    .rd    (r_s1_rd),
    .rs1   (r_s1_rs1),
    .rs2   (r_s1_rs2),
    .imm   (r_s1_imm),
    .legal (w_legal),
    .word  (w_word)
  );

  assign w_s1_move = r_s1_valid && (!out_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s1_move;
  assign w_in_fire = in_valid && in_ready;

  // S1: record holding stage; legality is evaluated from these registers
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_s1_valid <= 1'b0;
      r_s1_kind  <= 4'd0;
      r_s1_rd    <= 5'd0;
      r_s1_rs1   <= 5'd0;
      r_s1_rs2   <= 5'd0;
      r_s1_imm   <= 32'd0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (w_in_fire) begin
        r_s1_kind <= in_kind;
        r_s1_rd   <= in_rd;
        r_s1_rs1  <= in_rs1;
        r_s1_rs2  <= in_rs2;
        r_s1_imm  <= in_imm;
      end
    end
  end

  // S2: output register, address counter and reject bookkeeping
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      out_valid  <= 1'b0;
      out_instr  <= 32'd0;
      out_addr   <= BASE_ADDR;
      r_addr_cnt <= BASE_ADDR;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      if (w_s1_move && w_legal) begin
        out_valid  <= 1'b1;
        out_instr  <= w_word;
        out_addr   <= r_addr_cnt;
        r_addr_cnt <= r_addr_cnt + C_ADDR_STEP;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_s1_move && !w_legal) begin
        err_sticky <= 1'b1;
        if (err_count != {ERR_W{1'b1}}) begin
          err_count <= err_count + ERR_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire
